// File: rtl/csr_wb_sequencer.sv
// Serialises one committed instruction's CSR side-effects onto the single CSR
// write port and hands a done token to the retire side.
module csr_wb_sequencer #(
    parameter logic [7:0]  OP_ECALL     = 8'h01,
    parameter logic [7:0]  OP_MRET      = 8'h02,
    parameter logic [31:0] MEPC_ADDR    = 32'h341,
    parameter logic [31:0] MCAUSE_ADDR  = 32'h342,
    parameter logic [31:0] MCAUSE_ECALL = 32'd11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_pre_i,
    output logic        ready_pre_o,
    input  logic [31:0] pc_i,
    input  logic [7:0]  csr_op_i,
    input  logic        csr_wena_i,
    input  logic [31:0] csr_waddr_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_we_o,
    output logic [31:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,
    output logic        done_valid_o,
    input  logic        done_ready_i,
    output logic [7:0]  done_op_o,
    output logic [31:0] retire_cnt_o,
    output logic [1:0]  state_o
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid is never dropped until that transfer has taken place.
    typedef enum logic [1:0] {IDLE = 2'd0, WR0 = 2'd1, WR1 = 2'd2, DONE = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, waddr_q, wdata_q, cnt_q;
    logic [7:0]  op_q;
    logic        accept, is_ecall_q;

    assign accept     = (state_q == IDLE) && valid_pre_i;
    assign is_ecall_q = (op_q == OP_ECALL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            op_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pc_q    <= pc_i;
                op_q    <= csr_op_i;
                waddr_q <= csr_waddr_i;
                wdata_q <= csr_wdata_i;
            end
            if (state_q == DONE && done_ready_i) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    // ECALL always takes the two-write path, even if an explicit write rode along.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_pre_i) begin
                    if (csr_op_i == OP_ECALL || csr_wena_i) state_d = WR0;
                    else                                    state_d = DONE;
                end
            end
            WR0:     state_d = is_ecall_q ? WR1 : DONE;
            WR1:     state_d = DONE;
            DONE:    if (done_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_pre_o  = 1'b0;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        done_valid_o = 1'b0;
        done_op_o    = '0;
        case (state_q)
            IDLE: ready_pre_o = 1'b1;
            WR0: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = is_ecall_q ? MEPC_ADDR : waddr_q;
                csr_wdata_o = is_ecall_q ? pc_q : wdata_q;
            end
            WR1: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = MCAUSE_ADDR;
                csr_wdata_o = MCAUSE_ECALL;
            end
            DONE: begin
                done_valid_o = 1'b1;
                done_op_o    = op_q;
            end
            default: ;
        endcase
    end

    assign retire_cnt_o = cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_csr_wb_sequencer.sv
// Directed bench for csr_wb_sequencer: expected CSR writes and done tokens are
// queued when an operation is driven and checked as the DUT produces them.
module tb_csr_wb_sequencer;
  logic        clock;
  logic        reset;
  logic        valid_pre_i;
  logic        ready_pre_o;
  logic [31:0] pc_i;
  logic [7:0]  csr_op_i;
  logic        csr_wena_i;
  logic [31:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic        csr_we_o;
  logic [31:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        done_valid_o;
  logic        done_ready_i;
  logic [7:0]  done_op_o;
  logic [31:0] retire_cnt_o;
  logic [1:0]  state_o;

  logic [63:0] exp_q[$];
  logic [7:0]  done_q[$];
  int          tests = 0;
  int          fails = 0;

  csr_wb_sequencer dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .pc_i(pc_i), .csr_op_i(csr_op_i), .csr_wena_i(csr_wena_i),
    .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
    .done_op_o(done_op_o), .retire_cnt_o(retire_cnt_o), .state_o(state_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // driver: present one op and queue what it must produce
  task automatic drive_op(input logic [7:0] op, input logic [31:0] pc, input logic wena,
                          input logic [31:0] waddr, input logic [31:0] wdata);
    valid_pre_i = 1'b1;
    csr_op_i    = op;
    pc_i        = pc;
    csr_wena_i  = wena;
    csr_waddr_i = waddr;
    csr_wdata_i = wdata;
    if (op == 8'h01) begin
      exp_q.push_back({32'h341, pc});
      exp_q.push_back({32'h342, 32'd11});
    end else if (wena) begin
      exp_q.push_back({waddr, wdata});
    end
    done_q.push_back(op);
  endtask

  // scramble the input fields after acceptance; the DUT must not care
  task automatic release_inputs();
    valid_pre_i = 1'b0;
    csr_op_i    = 8'($urandom_range(0, 255));
    pc_i        = $urandom;
    csr_wena_i  = 1'($urandom_range(0, 1));
    csr_waddr_i = $urandom;
    csr_wdata_i = $urandom;
  endtask

  // scoreboard: writes and done handshakes popped against expectations
  always @(negedge clock) begin
    if (reset) begin
      if (csr_we_o) begin
        if (exp_q.size() == 0) check("unexpected_write", {csr_waddr_o, csr_wdata_o}, 64'hx);
        else check("csr_write", {csr_waddr_o, csr_wdata_o}, exp_q.pop_front());
      end
      if (done_valid_o && done_ready_i) begin
        if (done_q.size() == 0) check("unexpected_done", {56'd0, done_op_o}, 64'hx);
        else check("done_op", {56'd0, done_op_o}, {56'd0, done_q.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b0;
    done_ready_i = 1'b1;
    release_inputs();
    #12;
    check("rst_ready", ready_pre_o, 1);
    check("rst_we", csr_we_o, 0);
    check("rst_done", done_valid_o, 0);
    check("rst_cnt", retire_cnt_o, 0);
    reset = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_outputs", {ready_pre_o, csr_we_o, done_valid_o, retire_cnt_o}, {1'b1, 1'b0, 1'b0, 32'd0});
    end

    // ECALL with done_ready high
    drive_op(8'h01, 32'h8000_0010, 1'b0, 32'h0, 32'h0);
    step(); release_inputs();
    check("ecall_t1", {csr_we_o, csr_waddr_o, csr_wdata_o}, {1'b1, 32'h341, 32'h8000_0010});
    step();
    check("ecall_t2", {csr_we_o, csr_waddr_o, csr_wdata_o}, {1'b1, 32'h342, 32'd11});
    step();
    check("ecall_done", {done_valid_o, done_op_o, ready_pre_o}, {1'b1, 8'h01, 1'b0});
    step();
    check("ecall_retire", {retire_cnt_o, ready_pre_o}, {32'd1, 1'b1});

    // explicit write with done_ready low for three cycles
    done_ready_i = 1'b0;
    drive_op(8'h10, 32'h0, 1'b1, 32'h300, 32'h1888);
    step(); release_inputs();
    check("wr_t1", {csr_we_o, csr_waddr_o, csr_wdata_o}, {1'b1, 32'h300, 32'h1888});
    for (int i = 0; i < 3; i++) begin
      step();
      check("wr_hold", {done_valid_o, done_op_o, csr_we_o, retire_cnt_o}, {1'b1, 8'h10, 1'b0, 32'd1});
    end
    done_ready_i = 1'b1;
    step();
    check("wr_retire", {retire_cnt_o, ready_pre_o}, {32'd2, 1'b1});

    // MRET with no write; a second valid while busy is ignored
    done_ready_i = 1'b0;
    drive_op(8'h02, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    check("mret_done", {done_valid_o, done_op_o, csr_we_o}, {1'b1, 8'h02, 1'b0});
    valid_pre_i = 1'b1; csr_op_i = 8'h01; pc_i = 32'hDEAD_BEEF;
    check("mret_busy_ready", ready_pre_o, 0);
    step();
    check("mret_busy_hold", {done_valid_o, done_op_o, ready_pre_o}, {1'b1, 8'h02, 1'b0});
    release_inputs();
    done_ready_i = 1'b1;
    step();
    check("mret_retire", {retire_cnt_o, ready_pre_o}, {32'd3, 1'b1});

    // ECALL with explicit write requested: explicit write dropped
    drive_op(8'h01, 32'h0000_2468, 1'b1, 32'h305, 32'h5555);
    step(); release_inputs();
    step(); step();
    check("ecall_wena_done", {done_valid_o, done_op_o}, {1'b1, 8'h01});
    step();
    check("ecall_wena_cnt", retire_cnt_o, 4);

    // MRET with explicit write: one write cycle
    drive_op(8'h02, 32'h0, 1'b1, 32'h341, 32'h1234_0000);
    step(); release_inputs();
    check("mret_wena_we", csr_we_o, 1);
    step();
    check("mret_wena_done", {done_valid_o, csr_we_o}, {1'b1, 1'b0});
    step();

    // random explicit write, back-to-back with the previous op
    drive_op(8'($urandom_range(3, 255)), $urandom, 1'b1, 32'($urandom_range(0, 12'hFFF)), $urandom);
    step(); release_inputs();
    step(); step();
    check("rand_cnt", retire_cnt_o, 6);

    // reset during WR0 of an ECALL: only the mepc write may appear
    drive_op(8'h01, 32'h8000_0100, 1'b0, 32'h0, 32'h0);
    void'(exp_q.pop_back());
    void'(done_q.pop_back());
    step(); release_inputs();
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort_outputs", {ready_pre_o, csr_we_o, done_valid_o, done_op_o, retire_cnt_o, csr_waddr_o},
          {1'b1, 1'b0, 1'b0, 8'h00, 32'd0, 32'd0});
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_quiet", {csr_we_o, done_valid_o, ready_pre_o}, {1'b0, 1'b0, 1'b1});
    end

    // counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1;
    check("preload_cnt", retire_cnt_o, 32'hFFFF_FFFF);
    step();
    drive_op(8'h20, 32'h0, 1'b0, 32'h0, 32'h0);
    step(); release_inputs();
    check("wrap_done", done_valid_o, 1);
    step();
    check("wrap_cnt", retire_cnt_o, 0);

    step(); step();
    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
